// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - HEADER/LEN/payload/CHK frame extractor with checksum-gated payload drain.
// Optional inter-byte timeout enabled by defining UART_PARSER_TIMEOUT_EN.
module uart_frame_parser #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 156_250,
  localparam int        LW             = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    data,
  input  logic          data_flag,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] out_len,
  output logic          frame_ok,
  output logic          frame_err,
  output logic [1:0]    err_code,
  output logic          drop
);

  localparam int            IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [LW-1:0] IDX_ONE   = LW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [LW-1:0] wr_idx_q, wr_idx_d;
  logic [LW-1:0] rd_idx_q, rd_idx_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          drop_q, drop_d;
  logic          buf_we;
  logic [7:0]    payload_q [MAX_LEN];

`ifdef UART_PARSER_TIMEOUT_EN
  localparam int              TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    out_valid_d = out_valid_q;
    err_code_d  = err_code_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    drop_d      = 1'b0;
    buf_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (data_flag && data == HEADER) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (data_flag) begin
          if (data == 8'h00 || data > MAX_LEN_B) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
          end else begin
            state_d  = ST_PAYLOAD;
            len_d    = data[LW-1:0];
            sum_d    = data;
            wr_idx_d = '0;
          end
        end
      end
      ST_PAYLOAD: begin
        if (data_flag) begin
          buf_we   = 1'b1;
          sum_d    = sum_q + data;
          wr_idx_d = wr_idx_q + IDX_ONE;
          if (wr_idx_q == len_q - IDX_ONE) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (data_flag) begin
          if (data == sum_q) begin
            state_d     = ST_DRAIN;
            frame_ok_d  = 1'b1;
            out_valid_d = 1'b1;
            rd_idx_d    = '0;
          end else begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
          end
        end
      end
      ST_DRAIN: begin
        // Receive path is closed while draining; incoming bytes are only reported.
        drop_d = data_flag;
        if (out_valid_q && out_ready) begin
          if (rd_idx_q == len_q - IDX_ONE) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            rd_idx_d    = '0;
          end else begin
            rd_idx_d = rd_idx_q + IDX_ONE;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

`ifdef UART_PARSER_TIMEOUT_EN
    tmo_d = '0;
    // A byte arriving in the expiry cycle already cleared the counter above and wins.
    if ((state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CHK) && !data_flag) begin
      if (tmo_q == TMO_LAST) begin
        state_d     = ST_IDLE;
        frame_err_d = 1'b1;
        err_code_d  = 2'd3;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      sum_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
      drop_q      <= 1'b0;
`ifdef UART_PARSER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      drop_q      <= drop_d;
`ifdef UART_PARSER_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      payload_q[wr_idx_q[IW-1:0]] <= data;
    end
  end

  assign out_data  = out_valid_q ? payload_q[rd_idx_q[IW-1:0]] : 8'h00;
  assign out_valid = out_valid_q;
  assign out_len   = len_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - directed self-checking bench for uart_frame_parser.
// Timeout scenario follows UART_PARSER_TIMEOUT_EN the same way as the design.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int TMO     = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    data = 8'h00;
  logic          data_flag = 1'b0;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LW-1:0] out_len;
  logic          frame_ok;
  logic          frame_err;
  logic [1:0]    err_code;
  logic          drop;

  int checks = 0;
  int passed = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int valid_cnt = 0;

  uart_frame_parser #(
    .HEADER(8'hA5),
    .MAX_LEN(MAX_LEN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .data_flag(data_flag),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_len(out_len),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .err_code(err_code),
    .drop(drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_ok)  ok_cnt++;
    if (frame_err) err_cnt++;
    if (out_valid) valid_cnt++;
  end

  // Byte is presented for exactly one rising edge; returns on the following falling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data      = b;
    data_flag = 1'b1;
    @(negedge clk);
    data_flag = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_cycles(2);
    checks++;
    if ({out_data, out_valid, out_len, frame_ok, frame_err, err_code, drop} !== '0)
      $display("FAIL reset_outputs got data=%h v=%b len=%0d ok=%b err=%b code=%0d drop=%b want all 0",
               out_data, out_valid, out_len, frame_ok, frame_err, err_code, drop);
    else passed++;
    rst = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_basic_frame;
    int e0;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    e0 = err_cnt;
    out_ready = 1'b1;
    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'hA5); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h69);
    checks++;
    if (frame_ok !== 1'b1 || out_len !== 5'd3)
      $display("FAIL basic_frame_ok got ok=%b len=%0d want ok=1 len=3", frame_ok, out_len);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_b[i])
        $display("FAIL basic_byte%0d got v=%b data=%h want v=1 data=%h", i, out_valid, out_data, exp_b[i]);
      else passed++;
      if (i == 0) begin
        @(negedge clk);
        checks++;
        if (frame_ok !== 1'b0)
          $display("FAIL basic_ok_single got ok=%b want 0 on second drain cycle", frame_ok);
        else passed++;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (out_valid !== 1'b0 || err_cnt !== e0)
      $display("FAIL basic_end got v=%b errs=%0d want v=0 errs=%0d", out_valid, err_cnt, e0);
    else passed++;
  endtask

  task automatic test_bad_checksum;
    int v0;
    v0 = valid_cnt;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20);
    send_byte(8'h00);
    checks++;
    if (frame_err !== 1'b1 || err_code !== 2'd2 || frame_ok !== 1'b0)
      $display("FAIL bad_chk got err=%b code=%0d ok=%b want err=1 code=2 ok=0", frame_err, err_code, frame_ok);
    else passed++;
    idle_cycles(3);
    checks++;
    if (valid_cnt !== v0)
      $display("FAIL bad_chk_no_valid got valid_cycles=%0d want %0d", valid_cnt, v0);
    else passed++;
  endtask

  task automatic test_bad_len;
    logic [7:0] lens [2];
    lens[0] = 8'h00; lens[1] = 8'h11;
    for (int i = 0; i < 2; i++) begin
      send_byte(8'hA5); send_byte(lens[i]);
      checks++;
      if (frame_err !== 1'b1 || err_code !== 2'd1)
        $display("FAIL bad_len_%h got err=%b code=%0d want err=1 code=1", lens[i], frame_err, err_code);
      else passed++;
    end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    checks++;
    if (frame_ok !== 1'b1 || out_data !== 8'h7E || out_len !== 5'd1 || err_code !== 2'd1)
      $display("FAIL len1_frame got ok=%b data=%h len=%0d code=%0d want ok=1 data=7e len=1 code=1",
               frame_ok, out_data, out_len, err_code);
    else passed++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL len1_end got v=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_backpressure_drop;
    out_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
    send_byte(8'h67);
    checks++;
    if (frame_ok !== 1'b1 || out_data !== 8'hAA || out_len !== 5'd2)
      $display("FAIL bp_start got ok=%b data=%h len=%0d want ok=1 data=aa len=2", frame_ok, out_data, out_len);
    else passed++;
    idle_cycles(4);
    send_byte(8'hA5);
    checks++;
    if (drop !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hAA)
      $display("FAIL bp_drop got drop=%b v=%b data=%h want drop=1 v=1 data=aa", drop, out_valid, out_data);
    else passed++;
    idle_cycles(13);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hAA || drop !== 1'b0)
      $display("FAIL bp_hold got v=%b data=%h drop=%b want v=1 data=aa drop=0", out_valid, out_data, drop);
    else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hBB)
      $display("FAIL bp_second got v=%b data=%h want v=1 data=bb", out_valid, out_data);
    else passed++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL bp_end got v=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_cnt;
    out_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
`ifdef UART_PARSER_TIMEOUT_EN
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 4 * TMO && !seen; i++) begin
        @(negedge clk);
        if (frame_err) seen = 1'b1;
      end
      checks++;
      if (!seen || err_code !== 2'd3)
        $display("FAIL timeout_err got seen=%b code=%0d want seen=1 code=3", seen, err_code);
      else passed++;
    end
`else
    idle_cycles(200);
    checks++;
    if (err_cnt !== e0 || out_valid !== 1'b0)
      $display("FAIL no_timeout got errs=%0d v=%b want errs=%0d v=0", err_cnt, out_valid, e0);
    else passed++;
    send_byte(8'h20); send_byte(8'h32);
    checks++;
    if (frame_ok !== 1'b1 || out_data !== 8'h10)
      $display("FAIL late_bytes got ok=%b data=%h want ok=1 data=10", frame_ok, out_data);
    else passed++;
    idle_cycles(3);
`endif
  endtask

  task automatic test_reset_mid_frame;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_data, out_valid, out_len, frame_ok, frame_err, err_code, drop} !== '0)
      $display("FAIL midreset_outputs got v=%b len=%0d code=%0d err=%b want all 0",
               out_valid, out_len, err_code, frame_err);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05); send_byte(8'h06);
    checks++;
    if (frame_ok !== 1'b1 || out_data !== 8'h05 || out_valid !== 1'b1)
      $display("FAIL post_reset_frame got ok=%b v=%b data=%h want ok=1 v=1 data=05",
               frame_ok, out_valid, out_data);
    else passed++;
    idle_cycles(2);
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hFF); send_byte(8'h03); send_byte(8'h04);
    checks++;
    if (frame_ok !== 1'b1 || out_data !== 8'hFF)
      $display("FAIL b2b_first got ok=%b data=%h want ok=1 data=ff", frame_ok, out_data);
    else passed++;
    idle_cycles(2);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h80); send_byte(8'h81);
    checks++;
    if (frame_ok !== 1'b1 || out_data !== 8'h80 || out_len !== 5'd1)
      $display("FAIL b2b_second got ok=%b data=%h len=%0d want ok=1 data=80 len=1", frame_ok, out_data, out_len);
    else passed++;
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_bad_checksum();
    test_bad_len();
    test_backpressure_drop();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
